// File: rtl/rfs_wifi_timer_master_if.sv
// Avalon-MM bus between the timer master and the RFS_WiFi interval timer s1 port.
// The timer is a 16-bit responder with 3-bit word addresses and no waitrequest.
interface rfs_wifi_timer_master_if;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/rfs_wifi_timer_master.sv
// Hardware initiator that programs the RFS_WiFi interval timer, services its
// timeouts (irq or status polling) and fetches 32-bit counter snapshots.
module rfs_wifi_timer_master #(
    parameter int POLL_MODE = 0,
    parameter int TICK_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cfg_start,
    input  logic [31:0]                   cfg_period,
    input  logic                          cfg_continuous,
    input  logic                          cfg_stop,
    input  logic                          snap_req,
    rfs_wifi_timer_master_if.master       avm,
    input  logic                          irq,
    output logic                          busy,
    output logic                          running,
    output logic                          tick_pulse,
    output logic [TICK_W-1:0]             tick_count,
    output logic                          snap_valid,
    output logic [31:0]                   snap_value,
    output logic                          cfg_error
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, STOP_WR,
        SN_WR, SN_RL, SN_RH, SN_CAP
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         period_q, period_d;
    logic                cont_q, cont_d;
    logic                ret_run_q, ret_run_d;
    logic                running_q, running_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic [31:0]         snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;
    logic                cfg_error_q, cfg_error_d;
    logic [1:0]          stale_q, stale_d;

    logic [2:0]          addr_c;
    logic                cs_c, wn_c;
    logic [15:0]         wd_c;
    logic                timeout;

    // Status readdata is one cycle behind its address, so the first two RUN
    // cycles after any other state still show data from a different access.
    assign timeout = (POLL_MODE != 0) ? (avm.avm_readdata[0] && (stale_q == 2'd0)) : irq;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_q     <= '0;
            cont_q       <= 1'b0;
            ret_run_q    <= 1'b0;
            running_q    <= 1'b0;
            tick_count_q <= '0;
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
            cfg_error_q  <= 1'b0;
            stale_q      <= 2'd2;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            ret_run_q    <= ret_run_d;
            running_q    <= running_d;
            tick_count_q <= tick_count_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            cfg_error_q  <= cfg_error_d;
            stale_q      <= stale_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cont_d       = cont_q;
        ret_run_d    = ret_run_q;
        running_d    = running_q;
        tick_count_d = tick_count_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
        cfg_error_d  = 1'b0;
        tick_pulse   = 1'b0;
        addr_c       = 3'd0;
        cs_c         = 1'b0;
        wn_c         = 1'b1;
        wd_c         = 16'h0000;

        if (state_q != RUN)          stale_d = 2'd2;
        else if (stale_q != 2'd0)    stale_d = stale_q - 2'd1;
        else                         stale_d = 2'd0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_period != 32'd0) begin
                        period_d     = cfg_period;
                        cont_d       = cfg_continuous;
                        tick_count_d = '0;
                        state_d      = WR_PL;
                    end else begin
                        cfg_error_d  = 1'b1;
                    end
                end else if (snap_req) begin
                    ret_run_d = 1'b0;
                    state_d   = SN_WR;
                end
            end
            WR_PL: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd2; wd_c = period_q[15:0];
                state_d = WR_PH;
            end
            WR_PH: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd3; wd_c = period_q[31:16];
                state_d = WR_CTRL;
            end
            WR_CTRL: begin
                // ITO | START, plus CONT for periodic mode
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd1;
                wd_c = cont_q ? 16'h0007 : 16'h0005;
                running_d = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (POLL_MODE != 0) cs_c = 1'b1;
                if (timeout)        state_d = CLR_ST;
                else if (cfg_stop)  state_d = STOP_WR;
                else if (snap_req) begin
                    ret_run_d = 1'b1;
                    state_d   = SN_WR;
                end
            end
            CLR_ST: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd0; wd_c = 16'h0000;
                tick_pulse   = 1'b1;
                tick_count_d = tick_count_q + TICK_W'(1);
                if (cont_q) state_d = RUN;
                else begin
                    running_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            STOP_WR: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd1; wd_c = 16'h0008;
                running_d = 1'b0;
                state_d   = IDLE;
            end
            SN_WR: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd4;
                state_d = SN_RL;
            end
            SN_RL: begin
                cs_c = 1'b1; addr_c = 3'd4;
                state_d = SN_RH;
            end
            SN_RH: begin
                cs_c = 1'b1; addr_c = 3'd5;
                snap_value_d[15:0] = avm.avm_readdata;
                state_d = SN_CAP;
            end
            SN_CAP: begin
                snap_value_d[31:16] = avm.avm_readdata;
                snap_valid_d = 1'b1;
                state_d = ret_run_q ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign avm.avm_address    = addr_c;
    assign avm.avm_chipselect = cs_c;
    assign avm.avm_write_n    = wn_c;
    assign avm.avm_writedata  = wd_c;

    assign busy       = (state_q != IDLE) && (state_q != RUN);
    assign running    = running_q;
    assign tick_count = tick_count_q;
    assign snap_valid = snap_valid_q;
    assign snap_value = snap_value_q;
    assign cfg_error  = cfg_error_q;

endmodule

// File: tb/tb_rfs_wifi_timer_master.sv
// Directed bench: two masters (irq and polling variants) each driving a small
// behavioural model of the timer's s1 responder.
module tb_rfs_wifi_timer_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        start0 = 0, cont0 = 0, stop0 = 0, snap0 = 0;
    logic [31:0] per0 = 0;
    logic        start1 = 0, cont1 = 0, stop1 = 0, snap1 = 0;
    logic [31:0] per1 = 0;

    rfs_wifi_timer_master_if bus0();
    rfs_wifi_timer_master_if bus1();

    logic        irq0, busy0, running0, tp0, sv0, ce0;
    logic [31:0] tc0, sval0;
    logic        irq1, busy1, running1, tp1, sv1, ce1;
    logic [7:0]  tc1;
    logic [31:0] sval1;

    rfs_wifi_timer_master #(.POLL_MODE(0), .TICK_W(32)) u0 (
        .clk(clk), .reset_n(reset_n), .cfg_start(start0), .cfg_period(per0),
        .cfg_continuous(cont0), .cfg_stop(stop0), .snap_req(snap0), .avm(bus0.master),
        .irq(irq0), .busy(busy0), .running(running0), .tick_pulse(tp0),
        .tick_count(tc0), .snap_valid(sv0), .snap_value(sval0), .cfg_error(ce0));

    rfs_wifi_timer_master #(.POLL_MODE(1), .TICK_W(8)) u1 (
        .clk(clk), .reset_n(reset_n), .cfg_start(start1), .cfg_period(per1),
        .cfg_continuous(cont1), .cfg_stop(stop1), .snap_req(snap1), .avm(bus1.master),
        .irq(irq1), .busy(busy1), .running(running1), .tick_pulse(tp1),
        .tick_count(tc1), .snap_valid(sv1), .snap_value(sval1), .cfg_error(ce1));

    // Timer models: registered readdata, status cleared by any write, set by setN.
    logic [15:0] st0 = 0, ctl0 = 0, rd0 = 0, st1 = 0, ctl1 = 0, rd1 = 0;
    logic [31:0] sn0 = 0, cnt0 = 0, sn1 = 0, cnt1 = 0;
    logic        set0 = 0, set1 = 0;
    int          wcnt0 = 0, wcnt1 = 0;

    always @(posedge clk) begin
        case (bus0.avm_address)
            3'd0: rd0 <= st0;  3'd1: rd0 <= ctl0;
            3'd4: rd0 <= sn0[15:0]; 3'd5: rd0 <= sn0[31:16];
            default: rd0 <= 16'h0;
        endcase
        if (bus0.avm_chipselect && !bus0.avm_write_n) begin
            wcnt0 <= wcnt0 + 1;
            case (bus0.avm_address)
                3'd0: st0 <= 16'h0;
                3'd1: ctl0 <= bus0.avm_writedata;
                3'd4: sn0 <= cnt0;
                default: ;
            endcase
        end
        if (set0) st0[0] <= 1'b1;
    end

    always @(posedge clk) begin
        case (bus1.avm_address)
            3'd0: rd1 <= st1;  3'd1: rd1 <= ctl1;
            3'd4: rd1 <= sn1[15:0]; 3'd5: rd1 <= sn1[31:16];
            default: rd1 <= 16'h0;
        endcase
        if (bus1.avm_chipselect && !bus1.avm_write_n) begin
            wcnt1 <= wcnt1 + 1;
            case (bus1.avm_address)
                3'd0: st1 <= 16'h0;
                3'd1: ctl1 <= bus1.avm_writedata;
                3'd4: sn1 <= cnt1;
                default: ;
            endcase
        end
        if (set1) st1[0] <= 1'b1;
    end

    assign bus0.avm_readdata = rd0;
    assign bus1.avm_readdata = rd1;
    assign irq0 = st0[0] & ctl0[0];
    assign irq1 = st1[0] & ctl1[0];

    // {chipselect, write_n, address, writedata}
    wire [20:0] b0 = {bus0.avm_chipselect, bus0.avm_write_n, bus0.avm_address, bus0.avm_writedata};
    wire [20:0] b1 = {bus1.avm_chipselect, bus1.avm_write_n, bus1.avm_address, bus1.avm_writedata};
    localparam logic [20:0] BUS_IDLE = {1'b0, 1'b1, 3'd0, 16'h0};

    int nvec = 0, nerr = 0;

    task test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if ({b0, busy0, running0, tp0, sv0, ce0} !== {BUS_IDLE, 5'b0}) begin
            nerr++; $display("FAIL reset_out0: got %h want %h", {b0, busy0, running0, tp0, sv0, ce0}, {BUS_IDLE, 5'b0}); end
        nvec++; if ({tc0, sval0} !== 64'h0) begin
            nerr++; $display("FAIL reset_cnt0: got %h want 0", {tc0, sval0}); end
        nvec++; if ({b1, busy1, running1, tp1, sv1, ce1, tc1} !== {BUS_IDLE, 5'b0, 8'h0}) begin
            nerr++; $display("FAIL reset_out1: got %h want %h", {b1, busy1, running1, tp1, sv1, ce1, tc1}, {BUS_IDLE, 5'b0, 8'h0}); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task test_start_cont;
        per0 = 32'h0000C34F; cont0 = 1'b1; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        nvec++; if ({b0, busy0} !== {1'b1, 1'b0, 3'd2, 16'hC34F, 1'b1}) begin
            nerr++; $display("FAIL start_wr_pl: got %h want %h", {b0, busy0}, {1'b1, 1'b0, 3'd2, 16'hC34F, 1'b1}); end
        @(negedge clk);
        nvec++; if (b0 !== {1'b1, 1'b0, 3'd3, 16'h0000}) begin
            nerr++; $display("FAIL start_wr_ph: got %h want %h", b0, {1'b1, 1'b0, 3'd3, 16'h0000}); end
        @(negedge clk);
        nvec++; if ({b0, running0} !== {1'b1, 1'b0, 3'd1, 16'h0007, 1'b0}) begin
            nerr++; $display("FAIL start_wr_ctrl: got %h want %h", {b0, running0}, {1'b1, 1'b0, 3'd1, 16'h0007, 1'b0}); end
        @(negedge clk);
        nvec++; if ({b0, running0, busy0, tc0} !== {BUS_IDLE, 1'b1, 1'b0, 32'd0}) begin
            nerr++; $display("FAIL start_run: got %h want %h", {b0, running0, busy0, tc0}, {BUS_IDLE, 1'b1, 1'b0, 32'd0}); end
        for (int k = 1; k <= 3; k++) begin
            set0 = 1'b1; @(negedge clk); set0 = 1'b0;
            for (int i = 0; i < 10 && !tp0; i++) @(negedge clk);
            nvec++; if ({tp0, b0} !== {1'b1, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
                nerr++; $display("FAIL tick_clr_st%0d: got %h want %h", k, {tp0, b0}, {1'b1, 1'b1, 1'b0, 3'd0, 16'h0000}); end
            @(negedge clk);
            nvec++; if ({tc0, running0, tp0} !== {k[31:0], 1'b1, 1'b0}) begin
                nerr++; $display("FAIL tick_count%0d: got %h want %h", k, {tc0, running0, tp0}, {k[31:0], 1'b1, 1'b0}); end
        end
    endtask

    task test_snapshot;
        cnt0 = 32'h0000_1234; snap0 = 1'b1;
        @(negedge clk); snap0 = 1'b0;
        nvec++; if ({b0, busy0} !== {1'b1, 1'b0, 3'd4, 16'h0, 1'b1}) begin
            nerr++; $display("FAIL snap_w4: got %h want %h", {b0, busy0}, {1'b1, 1'b0, 3'd4, 16'h0, 1'b1}); end
        @(negedge clk);
        nvec++; if (b0 !== {1'b1, 1'b1, 3'd4, 16'h0}) begin
            nerr++; $display("FAIL snap_r4: got %h want %h", b0, {1'b1, 1'b1, 3'd4, 16'h0}); end
        @(negedge clk);
        nvec++; if (b0 !== {1'b1, 1'b1, 3'd5, 16'h0}) begin
            nerr++; $display("FAIL snap_r5: got %h want %h", b0, {1'b1, 1'b1, 3'd5, 16'h0}); end
        @(negedge clk);
        nvec++; if (sv0 !== 1'b0) begin
            nerr++; $display("FAIL snap_early: got %b want 0", sv0); end
        @(negedge clk);
        nvec++; if ({sv0, sval0, busy0, running0} !== {1'b1, 32'h0000_1234, 1'b0, 1'b1}) begin
            nerr++; $display("FAIL snap_value: got %h want %h", {sv0, sval0, busy0, running0}, {1'b1, 32'h0000_1234, 1'b0, 1'b1}); end
        @(negedge clk);
        nvec++; if (sv0 !== 1'b0) begin
            nerr++; $display("FAIL snap_pulse_width: got %b want 0", sv0); end
    endtask

    task test_irq_vs_stop;
        int w;
        set0 = 1'b1; @(negedge clk); set0 = 1'b0; stop0 = 1'b1;
        @(negedge clk); stop0 = 1'b0;
        nvec++; if ({tp0, b0} !== {1'b1, 1'b1, 1'b0, 3'd0, 16'h0}) begin
            nerr++; $display("FAIL prio_clr_first: got %h want %h", {tp0, b0}, {1'b1, 1'b1, 1'b0, 3'd0, 16'h0}); end
        @(negedge clk);
        w = wcnt0;
        repeat (3) @(negedge clk);
        nvec++; if ({wcnt0, running0, tc0} !== {w, 1'b1, 32'd4}) begin
            nerr++; $display("FAIL prio_stop_dropped: got %h want %h", {wcnt0, running0, tc0}, {w, 1'b1, 32'd4}); end
        stop0 = 1'b1; @(negedge clk); stop0 = 1'b0;
        nvec++; if ({b0, busy0} !== {1'b1, 1'b0, 3'd1, 16'h0008, 1'b1}) begin
            nerr++; $display("FAIL stop_write: got %h want %h", {b0, busy0}, {1'b1, 1'b0, 3'd1, 16'h0008, 1'b1}); end
        @(negedge clk);
        nvec++; if ({running0, busy0, b0} !== {1'b0, 1'b0, BUS_IDLE}) begin
            nerr++; $display("FAIL stop_idle: got %h want %h", {running0, busy0, b0}, {1'b0, 1'b0, BUS_IDLE}); end
    endtask

    task test_idle_snapshot;
        cnt0 = 32'hBEEF_0001; snap0 = 1'b1;
        @(negedge clk); snap0 = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        nvec++; if ({sv0, sval0, busy0, running0} !== {1'b1, 32'hBEEF_0001, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL idle_snap: got %h want %h", {sv0, sval0, busy0, running0}, {1'b1, 32'hBEEF_0001, 1'b0, 1'b0}); end
    endtask

    task test_oneshot;
        int w;
        per0 = 32'd20; cont0 = 1'b0; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk); @(negedge clk);
        nvec++; if (b0 !== {1'b1, 1'b0, 3'd1, 16'h0005}) begin
            nerr++; $display("FAIL oneshot_ctrl: got %h want %h", b0, {1'b1, 1'b0, 3'd1, 16'h0005}); end
        @(negedge clk);
        nvec++; if ({running0, tc0} !== {1'b1, 32'd0}) begin
            nerr++; $display("FAIL oneshot_run: got %h want %h", {running0, tc0}, {1'b1, 32'd0}); end
        set0 = 1'b1; @(negedge clk); set0 = 1'b0;
        for (int i = 0; i < 10 && !tp0; i++) @(negedge clk);
        nvec++; if ({tp0, b0} !== {1'b1, 1'b1, 1'b0, 3'd0, 16'h0}) begin
            nerr++; $display("FAIL oneshot_tick: got %h want %h", {tp0, b0}, {1'b1, 1'b1, 1'b0, 3'd0, 16'h0}); end
        @(negedge clk);
        nvec++; if ({running0, busy0, tc0} !== {1'b0, 1'b0, 32'd1}) begin
            nerr++; $display("FAIL oneshot_idle: got %h want %h", {running0, busy0, tc0}, {1'b0, 1'b0, 32'd1}); end
        w = wcnt0;
        set0 = 1'b1; @(negedge clk); set0 = 1'b0;
        repeat (10) @(negedge clk);
        nvec++; if ({wcnt0, tc0} !== {w, 32'd1}) begin
            nerr++; $display("FAIL oneshot_quiet: got %h want %h", {wcnt0, tc0}, {w, 32'd1}); end
    endtask

    task test_cfg_error;
        int w;
        w = wcnt0;
        per0 = 32'd0; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        nvec++; if ({ce0, busy0, b0} !== {1'b1, 1'b0, BUS_IDLE}) begin
            nerr++; $display("FAIL cfg_error_pulse: got %h want %h", {ce0, busy0, b0}, {1'b1, 1'b0, BUS_IDLE}); end
        @(negedge clk);
        nvec++; if ({ce0, wcnt0} !== {1'b0, w}) begin
            nerr++; $display("FAIL cfg_error_after: got %h want %h", {ce0, wcnt0}, {1'b0, w}); end
    endtask

    task test_reset_mid;
        int w;
        w = wcnt0;
        per0 = 32'h1234_5678; cont0 = 1'b1; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        nvec++; if (b0 !== {1'b1, 1'b0, 3'd2, 16'h5678}) begin
            nerr++; $display("FAIL rst_mid_pl: got %h want %h", b0, {1'b1, 1'b0, 3'd2, 16'h5678}); end
        @(negedge clk);
        nvec++; if (b0 !== {1'b1, 1'b0, 3'd3, 16'h1234}) begin
            nerr++; $display("FAIL rst_mid_ph: got %h want %h", b0, {1'b1, 1'b0, 3'd3, 16'h1234}); end
        reset_n = 1'b0;
        @(negedge clk);
        nvec++; if ({b0, busy0, running0, tp0, sv0, ce0, tc0, sval0} !== {BUS_IDLE, 5'b0, 64'h0}) begin
            nerr++; $display("FAIL rst_mid_out: got %h want %h", {b0, busy0, running0, tp0, sv0, ce0, tc0, sval0}, {BUS_IDLE, 5'b0, 64'h0}); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        nvec++; if ({wcnt0, running0, b0} !== {w + 2, 1'b0, BUS_IDLE}) begin
            nerr++; $display("FAIL rst_mid_quiet: got %h want %h", {wcnt0, running0, b0}, {w + 2, 1'b0, BUS_IDLE}); end
    endtask

    task test_poll;
        int n;
        per1 = 32'd10; cont1 = 1'b1; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        nvec++; if ({b1, running1} !== {1'b1, 1'b1, 3'd0, 16'h0, 1'b1}) begin
            nerr++; $display("FAIL poll_status_read: got %h want %h", {b1, running1}, {1'b1, 1'b1, 3'd0, 16'h0, 1'b1}); end
        n = 0;
        repeat (10) begin @(negedge clk); if (tp1) n++; end
        nvec++; if (n !== 0) begin
            nerr++; $display("FAIL poll_no_spurious: got %0d ticks want 0", n); end
        for (int k = 1; k <= 2; k++) begin
            set1 = 1'b1; @(negedge clk); set1 = 1'b0;
            n = 0;
            repeat (12) begin @(negedge clk); if (tp1) n++; end
            nvec++; if ({n, tc1} !== {32'd1, k[7:0]}) begin
                nerr++; $display("FAIL poll_tick%0d: got %h want %h", k, {n, tc1}, {32'd1, k[7:0]}); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start_cont();
        test_snapshot();
        test_irq_vs_stop();
        test_idle_snapshot();
        test_oneshot();
        test_cfg_error();
        test_reset_mid();
        test_poll();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
